// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg : shared mode/direction encodings and start-pattern helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BAR    = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Widest LED vector start_pat can describe; callers cast down to their width.
  localparam int LED_MAX = 256;

  function automatic logic [LED_MAX-1:0] start_pat(input logic [1:0] mode, input int n);
    logic [LED_MAX-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    case (mode)
      MODE_ROT_R: start_pat = one << (n - 1);
      MODE_BAR:   start_pat = '0;
      default:    start_pat = one;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_div.sv
// ---------------------------------------------------------------------------
// led_tick_div : two-rate step prescaler with hold and synchronous clear
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_tick_div #(
  parameter int DIV_FAST = 5000000,
  parameter int DIV_SLOW = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic speed,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
  localparam logic [CW-1:0] TERM_FAST = CW'(DIV_FAST - 1);
  localparam logic [CW-1:0] TERM_SLOW = CW'(DIV_SLOW - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] term;

  always_comb begin
    term  = speed ? TERM_FAST : TERM_SLOW;
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == term) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else if (cnt_q < term) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        // Count overshot a freshly shortened period: restart without stepping.
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_chaser_n.sv
// ---------------------------------------------------------------------------
// led_chaser_n : N-LED chaser with four patterns, run/hold and wrap pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_chaser_n
  import led_pkg::*;
#(
  parameter int N_LED    = 16,
  parameter int DIV_FAST = 5000000,
  parameter int DIV_SLOW = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             speed,
  input  logic             state_ctrl,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             clk_show,
  output logic             wrap
);

  generate
    if (N_LED < 2 || N_LED > LED_MAX || DIV_FAST < 1 || DIV_SLOW < DIV_FAST) begin : g_param_chk
      $error("led_chaser_n: illegal parameters N_LED=%0d DIV_FAST=%0d DIV_SLOW=%0d",
             N_LED, DIV_FAST, DIV_SLOW);
    end
  endgenerate

  logic [1:0]       mode_q;
  logic             dir_q;
  logic             dir_d;
  logic [N_LED-1:0] led_q;
  logic [N_LED-1:0] led_d;
  logic             clk_show_q;
  logic             wrap_q;
  logic             mode_chg;
  logic             tick;
  logic [N_LED-1:0] start_new;
  logic [N_LED-1:0] start_cur;

  assign mode_chg  = (mode != mode_q);
  assign start_new = N_LED'(start_pat(mode, N_LED));
  assign start_cur = N_LED'(start_pat(mode_q, N_LED));

  led_tick_div #(
    .DIV_FAST (DIV_FAST),
    .DIV_SLOW (DIV_SLOW)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (state_ctrl),
    .speed (speed),
    .clr   (mode_chg),
    .tick  (tick)
  );

  // Direction turns on the value being entered, so the end LED is shown once.
  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    case (mode_q)
      MODE_ROT_L: led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
      MODE_ROT_R: led_d = {led_q[0], led_q[N_LED-1:1]};
      MODE_BOUNCE: begin
        if (dir_q == DIR_UP) begin
          led_d = {led_q[N_LED-2:0], 1'b0};
          if (led_d[N_LED-1]) dir_d = DIR_DN;
        end else begin
          led_d = {1'b0, led_q[N_LED-1:1]};
          if (led_d[0]) dir_d = DIR_UP;
        end
      end
      default: begin
        if (dir_q == DIR_UP) begin
          led_d = {led_q[N_LED-2:0], 1'b1};
          if (&led_d) dir_d = DIR_DN;
        end else begin
          led_d = {1'b0, led_q[N_LED-1:1]};
          if (led_d == '0) dir_d = DIR_UP;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_ROT_L;
      dir_q      <= DIR_UP;
      led_q      <= {{(N_LED-1){1'b0}}, 1'b1};
      clk_show_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (mode_chg) begin
        mode_q <= mode;
        dir_q  <= DIR_UP;
        led_q  <= start_new;
      end else if (tick) begin
        led_q      <= led_d;
        dir_q      <= dir_d;
        clk_show_q <= ~clk_show_q;
        wrap_q     <= (led_d == start_cur) && (dir_d == DIR_UP);
      end
    end
  end

  assign led      = led_q;
  assign clk_show = clk_show_q;
  assign wrap     = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_led_chaser_n.sv
// ---------------------------------------------------------------------------
// tb_led_chaser_n : randomized and directed bench against a sequence-index model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_chaser_n;

  localparam int N  = 4;
  localparam int DF = 2;
  localparam int DS = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         speed;
  logic         state_ctrl;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic         clk_show;
  logic         wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pattern position is a step index into the mode's periodic sequence.
  int   m_mode;
  int   m_k;
  int   m_ph;
  logic m_show;
  logic m_wrap;
  bit   m_step;

  always #5 clk = ~clk;

  led_chaser_n #(
    .N_LED    (N),
    .DIV_FAST (DF),
    .DIV_SLOW (DS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .speed      (speed),
    .state_ctrl (state_ctrl),
    .mode       (mode),
    .led        (led),
    .clk_show   (clk_show),
    .wrap       (wrap)
  );

  function automatic int period(int md);
    if (md == 2) return 2*N - 2;
    if (md == 3) return 2*N;
    return N;
  endfunction

  function automatic logic [N-1:0] pat(int md, int k);
    int p;
    int pos;
    p   = 0;
    pos = 0;
    case (md)
      0: pos = k % N;
      1: pos = N - 1 - (k % N);
      2: begin
        p   = k % (2*N - 2);
        pos = (p < N) ? p : 2*N - 2 - p;
      end
      default: begin
        p   = k % (2*N);
        pos = (p <= N) ? p : 2*N - p;
        return N'((1 << pos) - 1);
      end
    endcase
    return N'(1 << pos);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_k    = 0;
    m_ph   = 0;
    m_show = 1'b0;
    m_wrap = 1'b0;
    m_step = 1'b0;
  endtask

  task automatic clk_cycle();
    int term;
    @(posedge clk);
    m_step = 1'b0;
    if (!rst) begin
      model_reset();
    end else begin
      m_wrap = 1'b0;
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode);
        m_k    = 0;
        m_ph   = 0;
      end else if (state_ctrl) begin
        term = speed ? DF : DS;
        if (m_ph == term - 1) begin
          m_k    = (m_k + 1) % period(m_mode);
          m_ph   = 0;
          m_show = ~m_show;
          m_wrap = (m_k == 0);
          m_step = 1'b1;
        end else if (m_ph < term - 1) begin
          m_ph++;
        end else begin
          m_ph = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] exp_seq [4];
    int idx;
    int wraps;
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    idx   = 0;
    wraps = 0;
    repeat (5) clk_cycle();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (led !== 4'b0001 || clk_show !== 1'b0 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: led=%b clk_show=%b wrap=%b, expected 0001 0 0", led, clk_show, wrap);
    end
    model_reset();
    clk_cycle();
    rst = 1'b1; mode = 2'd0; speed = 1'b1; state_ctrl = 1'b1;
    for (int c = 0; c < 9; c++) begin
      clk_cycle();
      n_checks++;
      if (led !== pat(m_mode, m_k) || clk_show !== m_show || wrap !== m_wrap) begin
        n_errors++;
        $display("FAIL reset_run: led=%b clk_show=%b wrap=%b, expected %b %b %b",
                 led, clk_show, wrap, pat(m_mode, m_k), m_show, m_wrap);
      end
      if (m_step) begin
        n_checks++;
        if (idx >= 4 || led !== exp_seq[idx]) begin
          n_errors++;
          $display("FAIL reset_seq: step %0d led=%b", idx, led);
        end
        idx++;
      end
      if (wrap === 1'b1) wraps++;
    end
    n_checks++;
    if (idx != 4 || wraps != 1) begin
      n_errors++;
      $display("FAIL reset_count: steps=%0d wraps=%0d, expected 4 1", idx, wraps);
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] exp_seq [6];
    int idx;
    int wraps;
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    idx   = 0;
    wraps = 0;
    mode  = 2'd2;
    clk_cycle();
    n_checks++;
    if (led !== 4'b0001 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL bounce_start: led=%b wrap=%b, expected 0001 0", led, wrap);
    end
    for (int c = 0; c < 13; c++) begin
      clk_cycle();
      n_checks++;
      if (led !== pat(m_mode, m_k) || clk_show !== m_show || wrap !== m_wrap) begin
        n_errors++;
        $display("FAIL bounce_run: led=%b clk_show=%b wrap=%b, expected %b %b %b",
                 led, clk_show, wrap, pat(m_mode, m_k), m_show, m_wrap);
      end
      if (m_step) begin
        n_checks++;
        if (idx >= 6 || led !== exp_seq[idx]) begin
          n_errors++;
          $display("FAIL bounce_seq: step %0d led=%b", idx, led);
        end
        idx++;
      end
      if (wrap === 1'b1) wraps++;
    end
    n_checks++;
    if (idx != 6 || wraps != 1) begin
      n_errors++;
      $display("FAIL bounce_count: steps=%0d wraps=%0d, expected 6 1", idx, wraps);
    end
  endtask

  task automatic test_bar();
    logic [N-1:0] exp_seq [8];
    int idx;
    int wraps;
    exp_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    idx   = 0;
    wraps = 0;
    mode  = 2'd3;
    clk_cycle();
    n_checks++;
    if (led !== 4'b0000) begin
      n_errors++;
      $display("FAIL bar_start: led=%b, expected 0000", led);
    end
    for (int c = 0; c < 17; c++) begin
      clk_cycle();
      n_checks++;
      if (led !== pat(m_mode, m_k) || clk_show !== m_show || wrap !== m_wrap) begin
        n_errors++;
        $display("FAIL bar_run: led=%b clk_show=%b wrap=%b, expected %b %b %b",
                 led, clk_show, wrap, pat(m_mode, m_k), m_show, m_wrap);
      end
      if (m_step) begin
        n_checks++;
        if (idx >= 8 || led !== exp_seq[idx]) begin
          n_errors++;
          $display("FAIL bar_seq: step %0d led=%b", idx, led);
        end
        idx++;
      end
      if (wrap === 1'b1) wraps++;
    end
    n_checks++;
    if (idx != 8 || wraps != 1) begin
      n_errors++;
      $display("FAIL bar_count: steps=%0d wraps=%0d, expected 8 1", idx, wraps);
    end
  endtask

  task automatic test_speed();
    bit           found;
    int           gap;
    int           k0;
    logic [N-1:0] prev;
    found = 1'b0;
    speed = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      clk_cycle();
      if (m_step) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL speed_sync: no step within 12 cycles, expected one");
    end
    prev = led;
    gap  = 0;
    for (int c = 1; c <= 10 && gap == 0; c++) begin
      clk_cycle();
      if (led !== prev) gap = c;
    end
    n_checks++;
    if (gap != DS) begin
      n_errors++;
      $display("FAIL speed_slow_gap: gap=%0d, expected %0d", gap, DS);
    end
    repeat (4) clk_cycle();
    k0    = m_k;
    speed = 1'b1;
    clk_cycle();
    n_checks++;
    if (led !== pat(m_mode, k0)) begin
      n_errors++;
      $display("FAIL speed_no_spurious: led=%b, expected %b", led, pat(m_mode, k0));
    end
    clk_cycle();
    clk_cycle();
    n_checks++;
    if (led !== pat(m_mode, k0 + 1) || clk_show !== m_show) begin
      n_errors++;
      $display("FAIL speed_fast_step: led=%b clk_show=%b, expected %b %b",
               led, clk_show, pat(m_mode, k0 + 1), m_show);
    end
  endtask

  task automatic test_hold();
    bit   found;
    int   k0;
    logic show0;
    found = 1'b0;
    speed = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      clk_cycle();
      if (m_step) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL hold_sync: no step within 12 cycles, expected one");
    end
    repeat (2) clk_cycle();
    k0         = m_k;
    show0      = m_show;
    state_ctrl = 1'b0;
    for (int c = 0; c < 20; c++) begin
      clk_cycle();
      n_checks++;
      if (led !== pat(m_mode, k0) || clk_show !== show0 || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_frozen: led=%b clk_show=%b wrap=%b, expected %b %b 0",
                 led, clk_show, wrap, pat(m_mode, k0), show0);
      end
    end
    state_ctrl = 1'b1;
    repeat (2) clk_cycle();
    n_checks++;
    if (led !== pat(m_mode, k0)) begin
      n_errors++;
      $display("FAIL hold_resume_early: led=%b, expected %b", led, pat(m_mode, k0));
    end
    clk_cycle();
    n_checks++;
    if (led !== pat(m_mode, k0 + 1) || clk_show !== ~show0) begin
      n_errors++;
      $display("FAIL hold_resume_step: led=%b clk_show=%b, expected %b %b",
               led, clk_show, pat(m_mode, k0 + 1), ~show0);
    end
  endtask

  task automatic test_mode_switch();
    speed = 1'b1;
    mode  = 2'd0;
    clk_cycle();
    clk_cycle();
    mode = 2'd1;
    clk_cycle();
    n_checks++;
    if (led !== 4'b1000 || wrap !== 1'b0 || clk_show !== m_show) begin
      n_errors++;
      $display("FAIL switch_on_tick: led=%b wrap=%b clk_show=%b, expected 1000 0 %b",
               led, wrap, clk_show, m_show);
    end
    state_ctrl = 1'b0;
    mode       = 2'd3;
    clk_cycle();
    n_checks++;
    if (led !== 4'b0000) begin
      n_errors++;
      $display("FAIL switch_in_hold_bar: led=%b, expected 0000", led);
    end
    mode = 2'd2;
    clk_cycle();
    n_checks++;
    if (led !== 4'b0001) begin
      n_errors++;
      $display("FAIL switch_in_hold_bounce: led=%b, expected 0001", led);
    end
    state_ctrl = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) speed = ~speed;
      if ($urandom_range(0, 11) == 0) state_ctrl = ~state_ctrl;
      clk_cycle();
      n_checks++;
      if (led !== pat(m_mode, m_k) || clk_show !== m_show || wrap !== m_wrap) begin
        n_errors++;
        $display("FAIL random: cycle %0d led=%b clk_show=%b wrap=%b, expected %b %b %b",
                 c, led, clk_show, wrap, pat(m_mode, m_k), m_show, m_wrap);
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    speed      = 1'b1;
    state_ctrl = 1'b1;
    mode       = 2'd0;
    model_reset();
    repeat (3) clk_cycle();
    rst = 1'b1;
    test_reset();
    test_bounce();
    test_bar();
    test_speed();
    test_hold();
    test_mode_switch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
